mem_stage_lsu: RTL and testbench

//  Parametrised successor to the memory stage: a load/store unit between execute and writeback.
//  - Stores are posted into an SB_DEPTH-entry store buffer; the buffer drains to a req/ack data-memory port.
//  - Loads access the same port, so the pipeline tolerates any memory latency.
//  - Non-memory ops pass through with one-cycle latency.

---
 rtl/mem_stage_lsu.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Load/store unit between execute and writeback: posted-store buffer draining to a req/ack port.
// Optional store-to-load forwarding is enabled by defining LSU_FWD_EN.
module mem_stage_lsu #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3,
  parameter int SB_DEPTH    = 4
) (
  input  logic                   ls_clk,
  input  logic                   ls_rst,
  input  logic                   ls_i_ce,
  input  logic                   ls_i_stall,
  input  logic                   ls_i_flush,
  input  logic                   ls_i_load,
  input  logic                   ls_i_store,
  input  logic [FUNCT_WIDTH-1:0] ls_i_funct3,
  input  logic [DWIDTH-1:0]      ls_i_alu_value,
  input  logic [DWIDTH-1:0]      ls_i_rs2_data,
  input  logic [AWIDTH-1:0]      ls_i_rd_addr,
  input  logic [DWIDTH-1:0]      ls_i_rd_data,
  input  logic                   ls_i_rd_we,
  output logic                   ls_o_ce,
  output logic                   ls_o_stall,
  output logic                   ls_o_flush,
  output logic [AWIDTH-1:0]      ls_o_rd_addr,
  output logic [DWIDTH-1:0]      ls_o_rd_data,
  output logic                   ls_o_rd_we,
  output logic [FUNCT_WIDTH-1:0] ls_o_funct3,
  output logic                   ls_o_misalign,
  output logic                   ls_m_req,
  output logic                   ls_m_we,
  output logic [DWIDTH-1:0]      ls_m_addr,
  output logic [DWIDTH-1:0]      ls_m_wdata,
  output logic [DWIDTH/8-1:0]    ls_m_be,
  input  logic                   ls_m_ack,
  input  logic [DWIDTH-1:0]      ls_m_rdata,
  output logic [1:0]             ls_dbg_state
);
  localparam int BW   = DWIDTH / 8;
  localparam int OFFW = $clog2(BW);
  localparam int PW   = $clog2(SB_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD_WAIT = 2'd1, DRAIN_WAIT = 2'd2} state_t;
  state_t state, next_state;

  function automatic logic [BW-1:0] size_mask(input logic [1:0] sz);
    logic [BW-1:0] m;
    for (int i = 0; i < BW; i++) m[i] = (i < (1 << sz));
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [OFFW-1:0] off);
    return (int'(off) & ((1 << sz) - 1)) != 0;
  endfunction

  // Shift the addressed lane down, then sign- or zero-extend by access size.
  function automatic logic [DWIDTH-1:0] lane_extract(input logic [DWIDTH-1:0] word,
                                                     input logic [OFFW-1:0] off,
                                                     input logic [FUNCT_WIDTH-1:0] f3);
    logic [DWIDTH-1:0] s, r;
    logic sgn;
    int nb;
    s = word >> {off, 3'b000};
    case (f3[1:0])
      2'd0:    begin nb = 8;      sgn = s[7];        end
      2'd1:    begin nb = 16;     sgn = s[15];       end
      2'd2:    begin nb = 32;     sgn = s[31];       end
      default: begin nb = DWIDTH; sgn = s[DWIDTH-1]; end
    endcase
    for (int i = 0; i < DWIDTH; i++) r[i] = (i < nb) ? s[i] : (sgn & ~f3[2]);
    return r;
  endfunction

  logic [DWIDTH-1:0] sb_addr [SB_DEPTH];
  logic [DWIDTH-1:0] sb_data [SB_DEPTH];
  logic [BW-1:0]     sb_be   [SB_DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr, sb_count;
  logic              sb_full, sb_empty, sb_push, sb_pop;

  logic                   ld_pend, ld_have, ld_rd_we;
  logic [DWIDTH-1:0]      ld_addr, ld_buf, ld_word;
  logic [BW-1:0]          ld_be;
  logic [FUNCT_WIDTH-1:0] ld_f3;
  logic [AWIDTH-1:0]      ld_rd_addr;

  logic              is_load, op_mem, in_misal, accept, ld_accept, ld_ack, ld_complete;
  logic              store_block, issue_load, issue_drain;
  logic [OFFW-1:0]   in_off;
  logic [BW-1:0]     in_be, q_be;
  logic [DWIDTH-1:0] in_word, q_word;
  logic              match_any, fwd_cover, fwd_hit, load_issue_ok;
  logic [PW-1:0]     match_idx, scan_idx;

  assign sb_count = wr_ptr - rd_ptr;
  assign sb_empty = (wr_ptr == rd_ptr);
  assign sb_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign is_load  = ls_i_load & ~ls_i_store;
  assign op_mem   = ls_i_load | ls_i_store;
  assign in_off   = ls_i_alu_value[OFFW-1:0];
  assign in_misal = op_mem & is_misaligned(ls_i_funct3[1:0], in_off);
  assign in_be    = size_mask(ls_i_funct3[1:0]) << in_off;
  assign in_word  = {ls_i_alu_value[DWIDTH-1:OFFW], {OFFW{1'b0}}};

  // The address compare serves the incoming load, or the parked one while it waits.
  assign q_word = ld_pend ? {ld_addr[DWIDTH-1:OFFW], {OFFW{1'b0}}} : in_word;
  assign q_be   = ld_pend ? ld_be : in_be;

  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    scan_idx  = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      scan_idx = rd_ptr[PW-1:0] + PW'(i);
      if (i < int'(sb_count) && sb_addr[scan_idx] == q_word) begin
        match_any = 1'b1;
        match_idx = scan_idx;
      end
    end
  end

  assign fwd_cover = match_any && ((sb_be[match_idx] & q_be) == q_be);
`ifdef LSU_FWD_EN
  assign fwd_hit       = fwd_cover;
  assign load_issue_ok = ~match_any;
`else
  assign fwd_hit       = 1'b0 & fwd_cover;
  assign load_issue_ok = sb_empty;
`endif

  assign sb_pop      = (state == DRAIN_WAIT) & ls_m_ack;
  assign ld_ack      = (state == LOAD_WAIT) & ls_m_ack;
  assign store_block = ls_i_ce & ~ls_i_flush & ls_i_store & ~in_misal & sb_full & ~sb_pop;
  assign ls_o_stall  = ls_i_stall | ld_pend | store_block;
  assign accept      = ls_i_ce & ~ls_o_stall & ~ls_i_flush;
  assign sb_push     = accept & ls_i_store & ~in_misal;
  assign ld_accept   = accept & is_load & ~in_misal & ~fwd_hit;
  assign ld_complete = ld_pend & (ld_have | ld_ack);
  assign ld_word     = ld_have ? ld_buf : ls_m_rdata;
  assign ls_dbg_state = state;

  always_comb begin
    next_state  = state;
    issue_load  = 1'b0;
    issue_drain = 1'b0;
    case (state)
      IDLE: begin
        if (ld_pend && !ld_have && load_issue_ok) begin
          issue_load = 1'b1;
          next_state = LOAD_WAIT;
        end else if (!sb_empty) begin
          issue_drain = 1'b1;
          next_state  = DRAIN_WAIT;
        end
      end
      LOAD_WAIT:  if (ls_m_ack) next_state = IDLE;
      DRAIN_WAIT: if (ls_m_ack) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge ls_clk) begin
    if (ls_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge ls_clk) begin
    if (sb_push) begin
      sb_addr[wr_ptr[PW-1:0]] <= in_word;
      sb_data[wr_ptr[PW-1:0]] <= ls_i_rs2_data << {in_off, 3'b000};
      sb_be[wr_ptr[PW-1:0]]   <= in_be;
    end
  end

  always_ff @(posedge ls_clk) begin
    if (ls_rst) begin
      wr_ptr <= '0; rd_ptr <= '0;
      ls_m_req <= 1'b0; ls_m_we <= 1'b0; ls_m_addr <= '0; ls_m_wdata <= '0; ls_m_be <= '0;
      ld_pend <= 1'b0; ld_have <= 1'b0; ld_buf <= '0; ld_addr <= '0; ld_be <= '0;
      ld_f3 <= '0; ld_rd_addr <= '0; ld_rd_we <= 1'b0;
      ls_o_ce <= 1'b0; ls_o_flush <= 1'b0; ls_o_rd_addr <= '0; ls_o_rd_data <= '0;
      ls_o_rd_we <= 1'b0; ls_o_funct3 <= '0; ls_o_misalign <= 1'b0;
    end else begin
      if (sb_push) wr_ptr <= wr_ptr + 1'b1;
      if (sb_pop)  rd_ptr <= rd_ptr + 1'b1;

      if (issue_load) begin
        ls_m_req <= 1'b1; ls_m_we <= 1'b0; ls_m_wdata <= '0; ls_m_be <= ld_be;
        ls_m_addr <= {ld_addr[DWIDTH-1:OFFW], {OFFW{1'b0}}};
      end else if (issue_drain) begin
        ls_m_req <= 1'b1; ls_m_we <= 1'b1;
        ls_m_addr  <= sb_addr[rd_ptr[PW-1:0]];
        ls_m_wdata <= sb_data[rd_ptr[PW-1:0]];
        ls_m_be    <= sb_be[rd_ptr[PW-1:0]];
      end else if (sb_pop || ld_ack) begin
        ls_m_req <= 1'b0;
      end

      if (ld_accept) begin
        ld_pend <= 1'b1; ld_addr <= ls_i_alu_value; ld_be <= in_be;
        ld_f3 <= ls_i_funct3; ld_rd_addr <= ls_i_rd_addr; ld_rd_we <= ls_i_rd_we;
      end
      // Read data arriving under a downstream stall is parked until the stall lifts.
      if (ld_ack && ls_i_stall) begin
        ld_have <= 1'b1;
        ld_buf  <= ls_m_rdata;
      end
      if (ld_complete && !ls_i_stall) begin
        ld_pend <= 1'b0;
        ld_have <= 1'b0;
      end

      if (!ls_i_stall) begin
        ls_o_flush <= ls_i_flush;
        if (ld_pend) begin
          ls_o_ce       <= ld_complete;
          ls_o_rd_we    <= ld_complete & ld_rd_we;
          ls_o_rd_addr  <= ld_rd_addr;
          ls_o_rd_data  <= lane_extract(ld_word, ld_addr[OFFW-1:0], ld_f3);
          ls_o_funct3   <= ld_f3;
          ls_o_misalign <= 1'b0;
        end else begin
          ls_o_ce       <= accept & ~ld_accept;
          ls_o_rd_we    <= accept & ~ld_accept & ~ls_i_store & ~in_misal & ls_i_rd_we;
          ls_o_rd_addr  <= ls_i_rd_addr;
          ls_o_rd_data  <= (is_load && fwd_hit) ?
                           lane_extract(sb_data[match_idx], in_off, ls_i_funct3) : ls_i_rd_data;
          ls_o_funct3   <= ls_i_funct3;
          ls_o_misalign <= accept & in_misal;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: retire scoreboard, memory-write scoreboard and a small memory responder.
module tb_mem_stage_lsu;
  localparam int W = 39;

  logic        ls_clk = 1'b0;
  logic        ls_rst;
  logic        ls_i_ce, ls_i_stall, ls_i_flush, ls_i_load, ls_i_store, ls_i_rd_we;
  logic [2:0]  ls_i_funct3;
  logic [31:0] ls_i_alu_value, ls_i_rs2_data, ls_i_rd_data;
  logic [4:0]  ls_i_rd_addr;
  logic        ls_o_ce, ls_o_stall, ls_o_flush, ls_o_rd_we, ls_o_misalign;
  logic [4:0]  ls_o_rd_addr;
  logic [31:0] ls_o_rd_data;
  logic [2:0]  ls_o_funct3;
  logic        ls_m_req, ls_m_we, ls_m_ack;
  logic [31:0] ls_m_addr, ls_m_wdata, ls_m_rdata;
  logic [3:0]  ls_m_be;
  logic [1:0]  ls_dbg_state;

  mem_stage_lsu dut (
    .ls_clk(ls_clk), .ls_rst(ls_rst), .ls_i_ce(ls_i_ce), .ls_i_stall(ls_i_stall),
    .ls_i_flush(ls_i_flush), .ls_i_load(ls_i_load), .ls_i_store(ls_i_store),
    .ls_i_funct3(ls_i_funct3), .ls_i_alu_value(ls_i_alu_value), .ls_i_rs2_data(ls_i_rs2_data),
    .ls_i_rd_addr(ls_i_rd_addr), .ls_i_rd_data(ls_i_rd_data), .ls_i_rd_we(ls_i_rd_we),
    .ls_o_ce(ls_o_ce), .ls_o_stall(ls_o_stall), .ls_o_flush(ls_o_flush),
    .ls_o_rd_addr(ls_o_rd_addr), .ls_o_rd_data(ls_o_rd_data), .ls_o_rd_we(ls_o_rd_we),
    .ls_o_funct3(ls_o_funct3), .ls_o_misalign(ls_o_misalign), .ls_m_req(ls_m_req),
    .ls_m_we(ls_m_we), .ls_m_addr(ls_m_addr), .ls_m_wdata(ls_m_wdata), .ls_m_be(ls_m_be),
    .ls_m_ack(ls_m_ack), .ls_m_rdata(ls_m_rdata), .ls_dbg_state(ls_dbg_state)
  );

  always #5 ls_clk = ~ls_clk;

  int n_tests = 0, n_fail = 0;
  logic [W-1:0]  exp_q[$];
  logic [67:0]   exp_mw_q[$];
  logic [31:0]   mem [logic [31:0]];
  int ack_delay = 1, wait_cnt = 0, last_req_cycles = 0, n_wr = 0, n_rd = 0;
  logic ack_hold = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after ack_delay request cycles unless held.
  initial begin
    logic [31:0] w;
    ls_m_ack = 1'b0; ls_m_rdata = '0;
    forever begin
      @(negedge ls_clk);
      ls_m_ack = 1'b0;
      if (ls_rst || !ls_m_req) wait_cnt = 0;
      else begin
        wait_cnt++;
        if (!ack_hold && wait_cnt >= ack_delay) begin
          ls_m_ack = 1'b1;
          last_req_cycles = wait_cnt;
          wait_cnt = 0;
          if (ls_m_we) begin
            n_wr++;
            if (exp_mw_q.size() == 0) check("mem_wr_unexpected", {ls_m_addr, ls_m_wdata, ls_m_be}, 0);
            else check("mem_wr", {ls_m_addr, ls_m_wdata, ls_m_be}, exp_mw_q.pop_front());
            w = mem.exists(ls_m_addr) ? mem[ls_m_addr] : 32'h0;
            for (int b = 0; b < 4; b++) if (ls_m_be[b]) w[8*b +: 8] = ls_m_wdata[8*b +: 8];
            mem[ls_m_addr] = w;
          end else begin
            n_rd++;
            ls_m_rdata = mem.exists(ls_m_addr) ? mem[ls_m_addr] : 32'h0;
          end
        end
      end
    end
  end

  // Retire monitor: one pop per retirement that is not being held by a downstream stall.
  initial begin
    logic held, rst_at_edge;
    forever begin
      @(posedge ls_clk);
      held = ls_i_stall;
      rst_at_edge = ls_rst;
      #1;
      if (ls_o_ce && !held && !rst_at_edge) begin
        if (exp_q.size() == 0)
          check("retire_unexpected", {ls_o_misalign, ls_o_rd_we, ls_o_rd_addr, ls_o_rd_data}, 0);
        else
          check("retire", {ls_o_misalign, ls_o_rd_we, ls_o_rd_addr,
                           ls_o_rd_we ? ls_o_rd_data : 32'h0}, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                      input logic [31:0] rdd, input logic we, input logic fl);
    int n = 0;
    @(negedge ls_clk);
    ls_i_ce = 1'b1; ls_i_load = ld; ls_i_store = st; ls_i_funct3 = f3;
    ls_i_alu_value = alu; ls_i_rs2_data = rs2; ls_i_rd_addr = rd; ls_i_rd_data = rdd;
    ls_i_rd_we = we; ls_i_flush = fl;
    #1;
    while (ls_o_stall && n < 300) begin
      @(negedge ls_clk); #1; n++;
    end
    if (n >= 300) check("send_timeout", 1, 0);
    @(posedge ls_clk); #1;
    ls_i_ce = 1'b0; ls_i_load = 1'b0; ls_i_store = 1'b0; ls_i_flush = 1'b0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] d, input logic fl);
    if (!fl) exp_q.push_back({1'b0, 1'b1, rd, d});
    send(1'b0, 1'b0, 3'b000, d, 32'h0, rd, d, 1'b1, fl);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                       input logic mis, input logic [67:0] mw);
    exp_q.push_back({mis, 1'b0, 5'd0, 32'h0});
    if (!mis) exp_mw_q.push_back(mw);
    send(1'b0, 1'b1, f3, addr, data, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                      input logic [31:0] exp_d, input logic mis);
    exp_q.push_back(mis ? {1'b1, 1'b0, rd, 32'h0} : {1'b0, 1'b1, rd, exp_d});
    send(1'b1, 1'b0, f3, addr, 32'h0, rd, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp_mw_q.size() != 0 || ls_m_req) && n < 500) begin
      @(negedge ls_clk); n++;
    end
    if (n >= 500) check("idle_timeout", 1, 0);
    repeat (2) @(negedge ls_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_before, wr_before, n;
    logic [31:0] d;
    logic [4:0]  r;
    ls_rst = 1'b1; ls_i_ce = 0; ls_i_stall = 0; ls_i_flush = 0; ls_i_load = 0; ls_i_store = 0;
    ls_i_funct3 = 0; ls_i_alu_value = 0; ls_i_rs2_data = 0; ls_i_rd_addr = 0; ls_i_rd_data = 0;
    ls_i_rd_we = 0;
    mem[32'h300] = 32'hABCD0000;
    mem[32'h500] = 32'h80FF7F01;
    repeat (3) @(negedge ls_clk);
    ls_rst = 1'b0;
    @(negedge ls_clk);
    check("rst_ce", ls_o_ce, 0);
    check("rst_outs", {ls_o_rd_we, ls_o_rd_addr, ls_o_rd_data, ls_o_misalign, ls_o_flush}, 0);
    check("rst_mem", {ls_m_req, ls_m_we, ls_m_addr, ls_m_be}, 0);
    check("rst_stall_state", {ls_o_stall, ls_dbg_state}, 0);

    // ALU pass-through
    alu_op(5'd5, 32'h1234, 1'b0);
    check("alu_no_req", ls_m_req, 0);
    alu_op(5'd6, 32'hFFFF_0001, 1'b0);
    wait_idle();

    // single store, ack after 3 request cycles
    ack_delay = 3;
    store(3'b010, 32'h100, 32'hDEADBEEF, 1'b0, {32'h100, 32'hDEADBEEF, 4'hF});
    wait_idle();
    check("sw_req_cycles", last_req_cycles, 3);
    check("sw_drained", {ls_m_req, ls_dbg_state}, 0);

    // fill the buffer with ack withheld; the fifth store must stall until the first ack
    ack_hold = 1'b1; ack_delay = 2;
    for (int i = 0; i < 4; i++) begin
      d = 32'h1111_0000 + i;
      store(3'b010, 32'h400 + 4 * i, d, 1'b0, {32'h400 + 4 * i, d, 4'hF});
    end
    @(negedge ls_clk);
    ls_i_ce = 1; ls_i_store = 1; ls_i_funct3 = 3'b010; ls_i_alu_value = 32'h410;
    ls_i_rs2_data = 32'h5555_AAAA; ls_i_rd_addr = 0; ls_i_rd_we = 0;
    #1 check("full_stall", ls_o_stall, 1);
    repeat (2) @(negedge ls_clk);
    #1 check("full_stall_held", ls_o_stall, 1);
    ack_hold = 1'b0;
    store(3'b010, 32'h410, 32'h5555_AAAA, 1'b0, {32'h410, 32'h5555_AAAA, 4'hF});
    wait_idle();
    ack_delay = 2;

    // store then byte load of the same word
    rd_before = n_rd;
    store(3'b010, 32'h200, 32'h80, 1'b0, {32'h200, 32'h80, 4'hF});
    load(3'b000, 32'h200, 5'd7, 32'hFFFFFF80, 1'b0);
`ifdef LSU_FWD_EN
    check("fwd_latency", {ls_o_ce, ls_o_rd_data}, {1'b1, 32'hFFFFFF80});
`else
    check("nofwd_wait", ls_o_ce, 0);
`endif
    wait_idle();
`ifdef LSU_FWD_EN
    check("lb_reads", n_rd - rd_before, 0);
`else
    check("lb_reads", n_rd - rd_before, 1);
`endif

    // forwarded halfword lanes, partial overlaps that must wait for memory
    store(3'b010, 32'h208, 32'h12345678, 1'b0, {32'h208, 32'h12345678, 4'hF});
    load(3'b101, 32'h20A, 5'd11, 32'h00001234, 1'b0);
    store(3'b010, 32'h20C, 32'h8000F00F, 1'b0, {32'h20C, 32'h8000F00F, 4'hF});
    load(3'b001, 32'h20E, 5'd12, 32'hFFFF8000, 1'b0);
    store(3'b000, 32'h204, 32'h55, 1'b0, {32'h204, 32'h55, 4'h1});
    load(3'b010, 32'h204, 5'd13, 32'h00000055, 1'b0);
    store(3'b001, 32'h212, 32'hBEEF, 1'b0, {32'h210, 32'hBEEF0000, 4'hC});
    load(3'b010, 32'h210, 5'd14, 32'hBEEF0000, 1'b0);
    wait_idle();

    // misaligned accesses, then aligned halfword from memory
    rd_before = n_rd; wr_before = n_wr;
    load(3'b101, 32'h301, 5'd15, 32'h0, 1'b1);
    store(3'b010, 32'h305, 32'h1, 1'b1, 68'h0);
    load(3'b010, 32'h302, 5'd16, 32'h0, 1'b1);
    load(3'b101, 32'h302, 5'd17, 32'h0000ABCD, 1'b0);
    wait_idle();
    check("misal_reads", n_rd - rd_before, 1);
    check("misal_writes", n_wr - wr_before, 0);

    // byte/half lanes from memory
    load(3'b000, 32'h501, 5'd18, 32'h0000007F, 1'b0);
    load(3'b000, 32'h502, 5'd19, 32'hFFFFFFFF, 1'b0);
    load(3'b100, 32'h503, 5'd20, 32'h00000080, 1'b0);
    load(3'b001, 32'h502, 5'd21, 32'hFFFF80FF, 1'b0);
    load(3'b010, 32'h500, 5'd22, 32'h80FF7F01, 1'b0);
    wait_idle();

    // random store/load pairs and ALU ops with random flushes
    for (int k = 0; k < 6; k++) begin
      d = $urandom;
      r = 5'($urandom_range(1, 31));
      ack_delay = $urandom_range(1, 4);
      store(3'b010, 32'h600 + 4 * k, d, 1'b0, {32'h600 + 4 * k, d, 4'hF});
      load(3'b010, 32'h600 + 4 * k, r, d, 1'b0);
    end
    for (int k = 0; k < 10; k++)
      alu_op(5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) == 0));
    wait_idle();

    // flush kills the slot and discards a flushed store
    send(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd3, 32'h77, 1'b1, 1'b1);
    check("flush_slot", {ls_o_ce, ls_o_rd_we, ls_o_flush}, 3'b001);
    send(1'b0, 1'b1, 3'b010, 32'h800, 32'h99, 5'd0, 32'h0, 1'b0, 1'b1);
    wait_idle();

    // downstream stall holds the output registers
    alu_op(5'd9, 32'hCAFE, 1'b0);
    ls_i_stall = 1'b1;
    repeat (3) @(negedge ls_clk);
    check("stall_hold", {ls_o_ce, ls_o_rd_addr, ls_o_rd_data}, {1'b1, 5'd9, 32'hCAFE});
    check("stall_up", ls_o_stall, 1);
    ls_i_stall = 1'b0;
    alu_op(5'd10, 32'hF00D, 1'b0);
    wait_idle();

    // reset in the middle of a drain with two entries buffered
    ack_hold = 1'b1;
    wr_before = n_wr;
    exp_q.push_back({1'b0, 1'b0, 5'd0, 32'h0});
    send(1'b0, 1'b1, 3'b010, 32'h700, 32'h7, 5'd0, 32'h0, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 5'd0, 32'h0});
    send(1'b0, 1'b1, 3'b010, 32'h704, 32'h8, 5'd0, 32'h0, 1'b0, 1'b0);
    n = 0;
    while (!ls_m_req && n < 20) begin @(negedge ls_clk); n++; end
    check("drain_started", {ls_m_req, ls_dbg_state}, {1'b1, 2'd2});
    @(negedge ls_clk);
    ls_rst = 1'b1;
    @(negedge ls_clk);
    check("rst_mid_req", {ls_m_req, ls_m_we, ls_m_addr, ls_m_wdata, ls_m_be}, 0);
    check("rst_mid_outs", {ls_o_ce, ls_o_rd_we, ls_o_rd_data, ls_o_stall, ls_dbg_state}, 0);
    ls_rst = 1'b0;
    ack_hold = 1'b0;
    repeat (10) @(negedge ls_clk);
    check("rst_buffer_empty", {ls_m_req, 32'(n_wr - wr_before)}, 0);
    check("leftover_retire", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
